// File: rtl/dac_pkg.sv
// Shared constants, FSM state type and sample-to-DAC-code conversion for the dual DAC writer.
package dac_pkg;

  localparam int DAC_WIDTH = 14;
  localparam logic [DAC_WIDTH-1:0] DAC_MIDSCALE = 14'h2000;
  localparam logic [DAC_WIDTH-1:0] DAC_SMIN = {1'b1, {(DAC_WIDTH-1){1'b0}}};
  localparam logic [DAC_WIDTH-1:0] DAC_SMAX = {1'b0, {(DAC_WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } dac_state_t;

  // Two's complement in, offset binary out; negation saturates the one unrepresentable value.
  function automatic logic [DAC_WIDTH-1:0] to_offset_bin(input logic [DAC_WIDTH-1:0] s,
                                                         input logic invert);
    logic [DAC_WIDTH-1:0] v;
    if (!invert)
      v = s;
    else if (s == DAC_SMIN)
      v = DAC_SMAX;
    else
      v = -s;
    return {~v[DAC_WIDTH-1], v[DAC_WIDTH-2:0]};
  endfunction

endpackage

// File: rtl/dac_fifo2.sv
// Two-entry FIFO with flush; head is visible combinationally on pop_dat, writes land next edge.
// Backpressure: push while full is dropped unless a pop shares the cycle; flush beats push and pop.
module dac_fifo2 #(
  parameter int DW = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] pop_dat,
  output logic [1:0]    occupancy,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem_q [2];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          do_push;
  logic          do_pop;

  assign empty     = (cnt_q == 2'd0);
  assign full      = (cnt_q == 2'd2);
  assign occupancy = cnt_q;
  assign pop_dat   = mem_q[rd_ptr_q];
  assign do_pop    = pop & ~empty;
  assign do_push   = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !flush)
      mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push)
        wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)
        rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/dac_dual_writer.sv
// Dual DAC writer: sample pairs -> 2-deep FIFO -> paced offset-binary DA/DB plus write clock.
// First pair appears DIV cycles after RUN entry; o_ready low while off or FIFO full.
// Define DAC_RAMP_EN to add the i_ramp_sel test-ramp source.
module dac_dual_writer
  import dac_pkg::*;
#(
  parameter int WIDTH  = DAC_WIDTH,
  parameter int DIV    = 10,
  parameter bit INVERT = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_RESET,
  input  logic             i_enable,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dataA,
  input  logic [WIDTH-1:0] i_dataB,
`ifdef DAC_RAMP_EN
  input  logic             i_ramp_sel,
`endif
  output logic [WIDTH-1:0] o_DA,
  output logic [WIDTH-1:0] o_DB,
  output logic             o_dac_clk,
  output logic             o_underrun
);

  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  dac_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dac_clk_d;
  logic               tick;
  logic               ramp_on;
  logic               fifo_push, fifo_pop, fifo_flush, fifo_empty, fifo_full;
  logic [1:0]         fifo_occ;
  logic [2*WIDTH-1:0] fifo_wr_dat, fifo_rd_dat;
  logic               load;
  logic [WIDTH-1:0]   load_a, load_b;

`ifdef DAC_RAMP_EN
  logic [WIDTH-1:0]   ramp_q;
  assign ramp_on = i_ramp_sel;

  always_ff @(posedge i_clock) begin
    if (i_RESET)
      ramp_q <= '0;
    else if (tick && ramp_on)
      ramp_q <= ramp_q + WIDTH'(1);
  end
`else
  assign ramp_on = 1'b0;
`endif

  assign o_ready     = (state_q != OFF) & ~fifo_full;
  assign tick        = (state_q == RUN) & (cnt_q == CNT_LAST) & i_enable;
  assign fifo_flush  = (state_d == OFF);
  assign fifo_push   = i_valid & o_ready;
  assign fifo_pop    = tick & ~ramp_on;
  // Conversion happens on the way in so the FIFO holds ready-to-drive codes.
  assign fifo_wr_dat = {to_offset_bin(i_dataA, INVERT), to_offset_bin(i_dataB, INVERT)};

  dac_fifo2 #(.DW(2*WIDTH)) u_fifo (
    .clk       (i_clock),
    .rst       (i_RESET),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_dat  (fifo_wr_dat),
    .pop       (fifo_pop),
    .pop_dat   (fifo_rd_dat),
    .occupancy (fifo_occ),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      OFF:     if (i_enable) state_d = PRIME;
      PRIME:   if (fifo_occ != 2'd0) state_d = RUN;
      RUN:     cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      default: state_d = OFF;
    endcase
    if (!i_enable) begin
      state_d = OFF;
      cnt_d   = '0;
    end
    // Registered from next-state so the clock phase lines up with cnt_q.
    dac_clk_d = (state_d == RUN) && (cnt_d >= CNT_HALF);
  end

  always_comb begin
    load   = tick & ~ramp_on & ~fifo_empty;
    load_a = fifo_rd_dat[2*WIDTH-1:WIDTH];
    load_b = fifo_rd_dat[WIDTH-1:0];
`ifdef DAC_RAMP_EN
    if (tick && ramp_on) begin
      load   = 1'b1;
      load_a = ramp_q;
      load_b = ~ramp_q;
    end
`endif
  end

  always_ff @(posedge i_clock) begin
    if (i_RESET) begin
      state_q    <= OFF;
      cnt_q      <= '0;
      o_dac_clk  <= 1'b0;
      o_DA       <= DAC_MIDSCALE;
      o_DB       <= DAC_MIDSCALE;
      o_underrun <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      o_dac_clk <= dac_clk_d;
      if (tick && !ramp_on && fifo_empty)
        o_underrun <= 1'b1;
      if (state_d == OFF) begin
        o_DA <= DAC_MIDSCALE;
        o_DB <= DAC_MIDSCALE;
      end else if (load) begin
        o_DA <= load_a;
        o_DB <= load_b;
      end
    end
  end

endmodule

// File: tb/tb_dac_dual_writer.sv
// Bench for dac_dual_writer: INVERT=0 and INVERT=1 instances share stimulus and are checked
// against a queue-based model that works in sample values and frame arithmetic.
module tb_dac_dual_writer;

  localparam int DIV = 10;
  localparam int W   = 14;
  localparam logic [W-1:0] MID = 14'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, en, vld;
  logic [W-1:0] a_in, b_in;
  logic         rdy0, rdy1, dclk0, dclk1, ur0, ur1;
  logic [W-1:0] da0, db0, da1, db1;
`ifdef DAC_RAMP_EN
  logic         ramp_sel;
  int           m_ramp;
`endif

  dac_dual_writer #(.WIDTH(W), .DIV(DIV), .INVERT(1'b0)) u_dut0 (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_valid(vld), .o_ready(rdy0),
    .i_dataA(a_in), .i_dataB(b_in),
`ifdef DAC_RAMP_EN
    .i_ramp_sel(ramp_sel),
`endif
    .o_DA(da0), .o_DB(db0), .o_dac_clk(dclk0), .o_underrun(ur0));

  dac_dual_writer #(.WIDTH(W), .DIV(DIV), .INVERT(1'b1)) u_dut1 (
    .i_clock(clk), .i_RESET(rst), .i_enable(en), .i_valid(vld), .o_ready(rdy1),
    .i_dataA(a_in), .i_dataB(b_in),
`ifdef DAC_RAMP_EN
    .i_ramp_sel(ramp_sel),
`endif
    .o_DA(da1), .o_DB(db1), .o_dac_clk(dclk1), .o_underrun(ur1));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of raw sample pairs, cycles since RUN entry, expected outputs.
  logic [2*W-1:0] mq [$];
  bit m_on, m_run;
  int m_rc;
  int m_loads = 0;
  int e_da0, e_db0, e_da1, e_db1;
  bit e_clk, e_ur, e_rdy;

  function automatic int conv(input logic [W-1:0] s, input bit inv);
    int v;
    v = $signed(s);
    if (inv) v = -v;
    if (v > 8191) v = 8191;
    return v + 8192;
  endfunction

  function automatic logic [W-1:0] rnd_sample();
    case ($urandom_range(0, 5))
      0: return 14'h2000;
      1: return 14'h1FFF;
      2: return 14'h0000;
      3: return 14'h3FFF;
      default: return W'($urandom);
    endcase
  endfunction

  function automatic void model_edge();
    int n0;
    bit tick;
    logic [2*W-1:0] p;
    n0 = mq.size();
    if (rst || !en) begin
      mq.delete();
      m_on = 0; m_run = 0; m_rc = 0; e_clk = 0;
      e_da0 = MID; e_db0 = MID; e_da1 = MID; e_db1 = MID;
      if (rst) begin
        e_ur = 0;
`ifdef DAC_RAMP_EN
        m_ramp = 0;
`endif
      end
    end else begin
      tick = m_run && (m_rc % DIV == DIV - 1);
      if (tick) begin
`ifdef DAC_RAMP_EN
        if (ramp_sel) begin
          e_da0 = m_ramp; e_db0 = 16383 - m_ramp;
          e_da1 = m_ramp; e_db1 = 16383 - m_ramp;
          m_ramp = (m_ramp + 1) % 16384;
          m_loads++;
        end else
`endif
        if (n0 > 0) begin
          p = mq.pop_front();
          e_da0 = conv(p[2*W-1:W], 0); e_db0 = conv(p[W-1:0], 0);
          e_da1 = conv(p[2*W-1:W], 1); e_db1 = conv(p[W-1:0], 1);
          m_loads++;
        end else begin
          e_ur = 1;
        end
      end
      if (e_rdy && vld) mq.push_back({a_in, b_in});
      if (m_run) m_rc++;
      else if (m_on && n0 > 0) begin m_run = 1; m_rc = 0; end
      m_on = 1;
      e_clk = m_run && (m_rc % DIV >= DIV / 2);
    end
    e_rdy = m_on && (mq.size() < 2);
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic push_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = 0;
    a_in = a; b_in = b; vld = 1'b1;
    while (!e_rdy && k < 4 * DIV) begin cycle(); k++; end
    cycle();
    vld = 1'b0;
    n_cmp++;
    if (k >= 4 * DIV) begin n_bad++; $display("FAIL push_wait waited %0d cycles, limit %0d", k, 4 * DIV); end
  endtask

  task automatic wait_loads(input int target);
    int k;
    k = 0;
    while (m_loads < target && k < 4 * DIV) begin cycle(); k++; end
    n_cmp++;
    if (m_loads < target) begin n_bad++; $display("FAIL load_wait loads=%0d need %0d", m_loads, target); end
  endtask

  task automatic reset_dut();
    rst = 1'b1; en = 1'b0; vld = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; vld = 1'b0; a_in = '0; b_in = '0;
    repeat (3) cycle();
    n_cmp++;
    if (da0 !== MID || db0 !== MID || da1 !== MID || db1 !== MID) begin
      n_bad++; $display("FAIL reset_codes got %h %h %h %h want 2000 each", da0, db0, da1, db1);
    end
    n_cmp++;
    if ({dclk0, dclk1, rdy0, rdy1, ur0, ur1} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl got %b want 000000", {dclk0, dclk1, rdy0, rdy1, ur0, ur1});
    end
    rst = 1'b0; en = 1'b1;
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL ready_before_enable_edge got %b want 0", rdy0); end
    cycle();
    n_cmp++;
    if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
      n_bad++; $display("FAIL ready_after_enable got %b%b want 11", rdy0, rdy1);
    end
  endtask

  task automatic test_conversion_timing();
    logic [W-1:0] exp_tab [3][4] = '{'{14'h2000, 14'h1FFF, 14'h2000, 14'h2001},
                                     '{14'h0000, 14'h3FFF, 14'h3FFF, 14'h0001},
                                     '{14'h0000, 14'h2000, 14'h3FFF, 14'h2000}};
    int base;
    int k;
    base = m_loads;
    push_pair(14'h0000, 14'h3FFF);
    push_pair(14'h2000, 14'h1FFF);
    push_pair(14'h2000, 14'h0000);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) wait_loads(base + i + 1);
      n_cmp++;
      if (da0 !== exp_tab[i][0] || db0 !== exp_tab[i][1]) begin
        n_bad++; $display("FAIL conv_pair%0d_inv0 got %h %h want %h %h", i, da0, db0, exp_tab[i][0], exp_tab[i][1]);
      end
      n_cmp++;
      if (da1 !== exp_tab[i][2] || db1 !== exp_tab[i][3]) begin
        n_bad++; $display("FAIL conv_pair%0d_inv1 got %h %h want %h %h", i, da1, db1, exp_tab[i][2], exp_tab[i][3]);
      end
      if (i == 1) begin
        n_cmp++;
        if (dclk0 !== 1'b0) begin n_bad++; $display("FAIL clk_at_load got %b want 0", dclk0); end
        k = 0;
        while (dclk0 !== 1'b1 && k < 2 * DIV) begin cycle(); k++; end
        n_cmp++;
        if (k != DIV / 2) begin n_bad++; $display("FAIL clk_rise_delay got %0d want %0d", k, DIV / 2); end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    reset_dut();
    en = 1'b1;
    cycle();
    acc = 0; vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a_in = W'($urandom); b_in = W'($urandom);
      if (rdy0) acc++;
      cycle();
    end
    n_cmp++;
    if (acc != 2) begin n_bad++; $display("FAIL accepts_before_pop got %0d want 2", acc); end
    n_cmp++;
    if (rdy0 !== 1'b0) begin n_bad++; $display("FAIL ready_when_full got %b want 0", rdy0); end
    for (int i = 0; i < 80; i++) begin
      a_in = rnd_sample(); b_in = rnd_sample();
      cycle();
      n_cmp++;
      if (rdy0 !== e_rdy || rdy1 !== e_rdy || da0 !== W'(e_da0) || db0 !== W'(e_db0) ||
          da1 !== W'(e_da1) || db1 !== W'(e_db1)) begin
        n_bad++;
        $display("FAIL stream cyc=%0d rdy=%b%b da/db=%h %h %h %h want rdy=%b %h %h %h %h", i, rdy0, rdy1,
                 da0, db0, da1, db1, e_rdy, W'(e_da0), W'(e_db0), W'(e_da1), W'(e_db1));
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_random();
    int dens;
    reset_dut();
    en = 1'b1;
    dens = 50;
    for (int i = 0; i < 600; i++) begin
      if (i % 60 == 0) dens = ($urandom_range(0, 2) == 0) ? 8 : (($urandom_range(0, 1) == 0) ? 50 : 100);
      vld  = ($urandom_range(0, 99) < dens);
      a_in = rnd_sample(); b_in = rnd_sample();
      cycle();
      n_cmp++;
      if (da0 !== W'(e_da0) || db0 !== W'(e_db0) || da1 !== W'(e_da1) || db1 !== W'(e_db1)) begin
        n_bad++;
        $display("FAIL rand_data cyc=%0d got %h %h %h %h want %h %h %h %h", i, da0, db0, da1, db1,
                 W'(e_da0), W'(e_db0), W'(e_da1), W'(e_db1));
      end
      n_cmp++;
      if ({rdy0, rdy1, dclk0, dclk1, ur0, ur1} !== {e_rdy, e_rdy, e_clk, e_clk, e_ur, e_ur}) begin
        n_bad++;
        $display("FAIL rand_ctrl cyc=%0d got rdy/clk/ur=%b want %b", i, {rdy0, rdy1, dclk0, dclk1, ur0, ur1},
                 {e_rdy, e_rdy, e_clk, e_clk, e_ur, e_ur});
      end
    end
    vld = 1'b0;
  endtask

  task automatic test_underrun();
    int base;
    int k;
    reset_dut();
    en = 1'b1;
    cycle();
    base = m_loads;
    push_pair(14'h0123, 14'h3ABC);
    wait_loads(base + 1);
    n_cmp++;
    if (ur0 !== 1'b0 || ur1 !== 1'b0) begin n_bad++; $display("FAIL underrun_first_tick got %b%b want 00", ur0, ur1); end
    k = 0;
    while (ur0 !== 1'b1 && k < 3 * DIV) begin cycle(); k++; end
    n_cmp++;
    if (k != DIV) begin n_bad++; $display("FAIL underrun_delay got %0d want %0d", k, DIV); end
    n_cmp++;
    if (da0 !== W'(conv(14'h0123, 0)) || db1 !== W'(conv(14'h3ABC, 1))) begin
      n_bad++; $display("FAIL underrun_hold got %h %h want %h %h", da0, db1, W'(conv(14'h0123, 0)), W'(conv(14'h3ABC, 1)));
    end
    en = 1'b0; cycle(); en = 1'b1;
    repeat (3) cycle();
    n_cmp++;
    if (ur0 !== 1'b1 || ur1 !== 1'b1) begin n_bad++; $display("FAIL underrun_sticky got %b%b want 11", ur0, ur1); end
    rst = 1'b1; cycle(); rst = 1'b0;
    n_cmp++;
    if (ur0 !== 1'b0 || ur1 !== 1'b0) begin n_bad++; $display("FAIL underrun_cleared got %b%b want 00", ur0, ur1); end
  endtask

  task automatic test_disable();
    int base;
    int k;
    reset_dut();
    en = 1'b1;
    cycle();
    base = m_loads;
    push_pair(14'h1111, 14'h2222);
    push_pair(14'h0333, 14'h0444);
    push_pair(14'h0555, 14'h0666);
    k = 0;
    while (dclk0 !== 1'b1 && k < 2 * DIV) begin cycle(); k++; end
    cycle();
    en = 1'b0;
    cycle();
    n_cmp++;
    if ({dclk0, dclk1, rdy0, rdy1} !== 4'b0000) begin
      n_bad++; $display("FAIL disable_ctrl got clk/rdy=%b want 0000", {dclk0, dclk1, rdy0, rdy1});
    end
    n_cmp++;
    if (da0 !== MID || db0 !== MID || da1 !== MID || db1 !== MID) begin
      n_bad++; $display("FAIL disable_codes got %h %h %h %h want 2000 each", da0, db0, da1, db1);
    end
    en = 1'b1;
    for (int i = 0; i < 3 * DIV; i++) begin
      cycle();
      n_cmp++;
      if (dclk0 !== 1'b0 || da0 !== MID || db1 !== MID || rdy0 !== e_rdy || m_loads != base + 1) begin
        n_bad++; $display("FAIL flushed_idle cyc=%0d clk=%b da0=%h db1=%h rdy=%b want 0 2000 2000 %b", i, dclk0, da0, db1, rdy0, e_rdy);
      end
    end
    push_pair(14'h0777, 14'h0888);
    k = 0;
    while (dclk0 !== 1'b1 && k < 4 * DIV) begin cycle(); k++; end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_cmp++;
    if ({dclk0, dclk1, rdy0} !== 3'b000 || da0 !== MID || db0 !== MID) begin
      n_bad++; $display("FAIL midframe_reset clk/rdy=%b da0=%h db0=%h want 000 2000 2000", {dclk0, dclk1, rdy0}, da0, db0);
    end
  endtask

`ifdef DAC_RAMP_EN
  task automatic test_ramp();
    int base;
    reset_dut();
    en = 1'b1; ramp_sel = 1'b1;
    cycle();
    base = m_loads;
    push_pair(14'h1234, 14'h0567);
    for (int t = 0; t < 5; t++) begin
      wait_loads(base + t + 1);
      n_cmp++;
      if (da0 !== W'(t) || db0 !== W'(16383 - t) || da1 !== W'(t) || ur0 !== 1'b0) begin
        n_bad++; $display("FAIL ramp step %0d got %h %h %h ur=%b want %h %h %h 0", t, da0, db0, da1, ur0, W'(t), W'(16383 - t), W'(t));
      end
    end
    ramp_sel = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b0; vld = 1'b0; a_in = '0; b_in = '0;
`ifdef DAC_RAMP_EN
    ramp_sel = 1'b0;
`endif
    test_reset();
    test_conversion_timing();
    test_backpressure();
    test_random();
    test_underrun();
    test_disable();
`ifdef DAC_RAMP_EN
    test_ramp();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
